perf_event_monitor: RTL and testbench
=====================================

# perf_event_monitor

Synthesizable performance monitor that sits beside the pipelined CPU and counts elapsed cycles plus NUM_EVENTS single-bit pipeline events (stall, flush, retire, and so on). It runs a bounded measurement window and provides atomic snapshots with a registered read port. Overflow handling is selectable per instance. It moves stall/flush/cycle accounting out of simulation-only code and into RTL, so the same counts are available in silicon and in every test.

## Interface
Parameters:
- NUM_EVENTS, 4: number of event inputs; ≥1.
- CNT_WIDTH, 32: width of every counter, including the cycle counter; ≥2.
- SATURATE, 0: 0 = counters wrap and set a sticky overflow bit; 1 = counters hold at all-ones and set the sticky bit.
- CYCLE_LIMIT, 64: length of the measurement window in counted cycles; 0 = unbounded.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: reset, asynchronous, active-high.
- start_i, in, 1: run enable; level-sensitive.
- clear_i, in, 1: synchronous clear of counters and state.
- event_i, in, NUM_EVENTS: event strobes, sampled every clock.
- snap_i, in, 1: capture all live counters into shadow registers.
- rd_sel_i, in, $clog2(NUM_EVENTS+1): shadow index; 0..NUM_EVENTS-1 = events, NUM_EVENTS = cycle counter.
- rd_data_o, out, CNT_WIDTH: registered shadow read data.
- snap_valid_o, out, 1: one-cycle pulse after a snapshot is captured.
- overflow_o, out, NUM_EVENTS+1: sticky live overflow flags; MSB = cycle counter.
- running_o, out, 1: state == RUN.
- done_o, out, 1: state == DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on an edge with start_i=1. No counting happens on that edge.
- RUN:
  - Each edge with start_i=1, the cycle counter increments.
  - Event counter k increments when event_i[k]=1 on that edge.
  - An edge with start_i=0 pauses counting; the state stays RUN.
- RUN → DONE on the edge where the cycle counter becomes CYCLE_LIMIT. Events on that edge are counted, so exactly CYCLE_LIMIT cycles are observed.
- DONE: counters are frozen, start_i is ignored, and the state holds until clear_i or reset.
- With CYCLE_LIMIT=0, DONE is never entered.
- clear_i:
  - Zeros all live counters and overflow flags and forces IDLE.
  - Shadow registers are untouched.
  - Priority: rst_i > clear_i > snap_i > counting.
- snap_i:
  - Copies all NUM_EVENTS+1 live counters into the shadows.
  - The copy uses the pre-increment values of the same edge.
  - Snapshots are legal in any state.
  - snap_i together with clear_i: the clear wins and no snapshot is taken.
- Overflow:
  - An increment from all-ones sets that counter's overflow bit; the bit stays set until clear or reset.
  - Wrap mode: the counter goes to 0.
  - Saturate mode: the counter stays at all-ones.
- Cycle counter overflow:
  - Only possible when CYCLE_LIMIT=0 or CYCLE_LIMIT > 2^CNT_WIDTH-1.
  - Elaboration must reject CYCLE_LIMIT > 2^CNT_WIDTH-1.
- Read: rd_data_o ← shadow[rd_sel_i] each edge. An out-of-range rd_sel_i returns 0.

## Timing
- Reset values: all counters, shadows, and overflow flags = 0. State = IDLE. rd_data_o=0, snap_valid_o=0, running_o=0, done_o=0.
- Reset asserted mid-window aborts it immediately and asynchronously; no partial values are retained.
- Counter update latency: 0. The value after edge n includes event_i sampled at edge n.
- snap_valid_o is high for exactly the one cycle following the capturing edge.
- Read latency: 1 cycle from rd_sel_i to rd_data_o.
- A read in the same cycle as snap_valid_o returns the new snapshot, because that read registers at the edge after capture.
- Back-to-back snap_i on consecutive edges is legal. Each capture overwrites the previous one, and snap_valid_o stays high.
- done_o rises in the cycle after the edge on which the cycle counter reaches the limit.

## Structure
- Shared package perf_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the overflow mode constants MODE_WRAP and MODE_SAT;
  - the default CNT_WIDTH.
- Sub-module perf_counter_cell:
  - One CNT_WIDTH counter with inc/clear/mode inputs, a count output, and a sticky overflow output.
  - Instantiated NUM_EVENTS+1 times in a generate loop.
- The top level holds the FSM, the shadow array, and the read mux.

## Test plan
1. NUM_EVENTS=2, CNT_WIDTH=8, CYCLE_LIMIT=64. Hold start_i=1, pulse event_i[0] every 4th counted cycle and event_i[1] every cycle.
   - Expect cycle=64, ev0=16, ev1=64.
   - Expect done_o set, with no further change afterwards.
2. Pause: start_i=1 for 10 cycles, 0 for 5, 1 for 10, with event_i[0]=1 throughout. Then snap and read.
   - Expect cycle=20 and ev0=20.
3. Wrap vs. saturate, with CNT_WIDTH=4 and CYCLE_LIMIT=0: 18 event cycles.
   - SATURATE=0: ev0=2, overflow_o[0]=1.
   - SATURATE=1: ev0=15, overflow_o[0]=1.
4. snap_i with event_i[0]=1 on the same edge, with live ev0=7.
   - Expect shadow=7 and live=8.
   - snap_valid_o pulses for 1 cycle.
   - rd_sel_i=0 yields 7 one cycle later.
5. clear_i and snap_i on the same edge at live ev0=5.
   - Expect live=0, state IDLE, shadow unchanged, and no snap_valid_o pulse.
6. Assert rst_i asynchronously between clock edges at cycle 30.
   - All outputs drop to 0 before the next edge.
   - Restarting the window gives cycle=64 at done.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: shared definitions for the performance event monitor.
//   state_t            - monitor FSM states (IDLE / RUN / DONE)
//   MODE_WRAP/MODE_SAT - counter overflow behaviour select
//   DEFAULT_CNT_WIDTH  - default width of every counter
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int DEFAULT_CNT_WIDTH = 32;

endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one up-counter with sticky overflow flag.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   clear    - synchronous clear of count and overflow (wins over inc)
//   inc      - increment request for this edge
//   mode     - MODE_WRAP: roll to 0 on overflow; MODE_SAT: hold at all-ones
//   count    - live count value
//   overflow - sticky, set by an increment from all-ones
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             overflow
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        overflow <= 1'b1;
        count    <= (mode == MODE_SAT) ? count : '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_event_monitor.sv
// perf_event_monitor: counts elapsed cycles and NUM_EVENTS pipeline event
// strobes over a bounded measurement window, with atomic snapshots into
// shadow registers and a registered read port.
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - asynchronous active-high reset
//   start_i      - run enable (level); pauses counting when low in RUN
//   clear_i      - synchronous clear of live counters, flags and state
//   event_i      - event strobes, one bit per event counter
//   snap_i       - copy live counters into shadows (pre-increment values)
//   rd_sel_i     - shadow index; NUM_EVENTS selects the cycle counter
//   rd_data_o    - registered shadow read data (0 for out-of-range index)
//   snap_valid_o - high the cycle after a capture
//   overflow_o   - sticky live overflow flags, MSB = cycle counter
//   running_o    - state is RUN
//   done_o       - state is DONE
module perf_event_monitor
  import perf_pkg::*;
#(
  parameter int          NUM_EVENTS  = 4,
  parameter int          CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int          SATURATE    = 0,
  parameter int unsigned CYCLE_LIMIT = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic                              clear_i,
  input  logic [NUM_EVENTS-1:0]             event_i,
  input  logic                              snap_i,
  input  logic [$clog2(NUM_EVENTS+1)-1:0]   rd_sel_i,
  output logic [CNT_WIDTH-1:0]              rd_data_o,
  output logic                              snap_valid_o,
  output logic [NUM_EVENTS:0]               overflow_o,
  output logic                              running_o,
  output logic                              done_o
);

  localparam int SEL_W = $clog2(NUM_EVENTS + 1);
  localparam int CYC   = NUM_EVENTS;  // slot of the cycle counter

  if (NUM_EVENTS < 1) begin : g_bad_num_events
    $error("perf_event_monitor: NUM_EVENTS must be >= 1");
  end
  if (CNT_WIDTH < 2) begin : g_bad_cnt_width
    $error("perf_event_monitor: CNT_WIDTH must be >= 2");
  end
  // A window longer than the cycle counter can represent would never end.
  if (64'(CYCLE_LIMIT) > ((64'd1 << CNT_WIDTH) - 64'd1)) begin : g_bad_limit
    $error("perf_event_monitor: CYCLE_LIMIT exceeds cycle counter range");
  end

  localparam logic [CNT_WIDTH-1:0] LIMIT_M1 =
    (CYCLE_LIMIT == 0) ? '0 : CNT_WIDTH'(CYCLE_LIMIT - 1);
  localparam logic CNT_MODE = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;

  state_t                 state, state_nxt;
  logic                   count_en;
  logic                   reach_limit;
  logic [NUM_EVENTS:0]    inc;
  logic [CNT_WIDTH-1:0]   live   [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0]   shadow [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0]   rd_mux;

  assign count_en = (state == RUN) && start_i && !clear_i;

  // Compare against the pre-increment value so DONE is entered on the
  // same edge the cycle counter reaches CYCLE_LIMIT.
  assign reach_limit = (CYCLE_LIMIT != 0) && (live[CYC] == LIMIT_M1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = RUN;
      RUN:     if (start_i && reach_limit) state_nxt = DONE;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (clear_i) state_nxt = IDLE;
  end

  assign running_o = (state == RUN);
  assign done_o    = (state == DONE);

  for (genvar k = 0; k <= NUM_EVENTS; k++) begin : g_cnt
    if (k == CYC) begin : g_cycle
      assign inc[k] = count_en;
    end else begin : g_event
      assign inc[k] = count_en & event_i[k];
    end

    perf_counter_cell #(
      .WIDTH (CNT_WIDTH)
    ) u_cell (
      .clk      (clk_i),
      .rst      (rst_i),
      .clear    (clear_i),
      .inc      (inc[k]),
      .mode     (CNT_MODE),
      .count    (live[k]),
      .overflow (overflow_o[k])
    );
  end

  // Shadows see the registered (pre-increment) live values of this edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k <= NUM_EVENTS; k++) shadow[k] <= '0;
      snap_valid_o <= 1'b0;
    end else begin
      snap_valid_o <= snap_i && !clear_i;
      if (snap_i && !clear_i) begin
        for (int k = 0; k <= NUM_EVENTS; k++) shadow[k] <= live[k];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (rd_sel_i <= SEL_W'(NUM_EVENTS)) rd_mux = shadow[rd_sel_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_o <= '0;
    else       rd_data_o <= rd_mux;
  end

endmodule

// File: tb/tb_perf_event_monitor.sv
module tb_perf_event_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       clear;
  logic [1:0] ev;
  logic       snap;
  logic [1:0] rd_sel;

  logic [7:0] rd_a;
  logic [3:0] rd_b, rd_c;
  logic       sv_a, sv_b, sv_c;
  logic [2:0] ovf_a, ovf_b, ovf_c;
  logic       run_a, run_b, run_c;
  logic       done_a, done_b, done_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // A: bounded window; B/C: unbounded 4-bit counters, wrap vs saturate.
  perf_event_monitor #(
    .NUM_EVENTS(2), .CNT_WIDTH(8), .SATURATE(0), .CYCLE_LIMIT(64)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .event_i(ev), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_a),
    .snap_valid_o(sv_a), .overflow_o(ovf_a), .running_o(run_a), .done_o(done_a)
  );

  perf_event_monitor #(
    .NUM_EVENTS(2), .CNT_WIDTH(4), .SATURATE(0), .CYCLE_LIMIT(0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .event_i(ev), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_b),
    .snap_valid_o(sv_b), .overflow_o(ovf_b), .running_o(run_b), .done_o(done_b)
  );

  perf_event_monitor #(
    .NUM_EVENTS(2), .CNT_WIDTH(4), .SATURATE(1), .CYCLE_LIMIT(0)
  ) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear),
    .event_i(ev), .snap_i(snap), .rd_sel_i(rd_sel), .rd_data_o(rd_c),
    .snap_valid_o(sv_c), .overflow_o(ovf_c), .running_o(run_c), .done_o(done_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; snap = 1'b0; ev = 2'b00; rd_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_running", 32'(run_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_snap_valid", 32'(sv_a), 32'd0);
    check("rst_rd_data", 32'(rd_a), 32'd0);
    check("rst_overflow", 32'(ovf_a), 32'd0);
    rst = 1'b0;
    tick();

    // 1: full window, ev0 every 4th counted cycle, ev1 every cycle
    start = 1'b1;
    tick();
    check("t1_running", 32'(run_a), 32'd1);
    for (int i = 0; i < 64; i++) begin
      ev = {1'b1, (i % 4 == 0)};
      if (i == 63) check("t1_done_before_last", 32'(done_a), 32'd0);
      tick();
    end
    check("t1_done", 32'(done_a), 32'd1);
    check("t1_not_running", 32'(run_a), 32'd0);
    ev = 2'b11;
    repeat (5) tick();
    check("t1_done_holds", 32'(done_a), 32'd1);
    snap = 1'b1; rd_sel = 2'd0;
    tick();
    snap = 1'b0;
    check("t1_snap_valid", 32'(sv_a), 32'd1);
    tick();
    check("t1_ev0", 32'(rd_a), 32'd16);
    check("t1_snap_valid_low", 32'(sv_a), 32'd0);
    rd_sel = 2'd1; tick();
    check("t1_ev1", 32'(rd_a), 32'd64);
    rd_sel = 2'd2; tick();
    check("t1_cycle", 32'(rd_a), 32'd64);
    rd_sel = 2'd3; tick();
    check("t1_rd_out_of_range", 32'(rd_a), 32'd0);
    check("t1_no_overflow", 32'(ovf_a), 32'd0);

    // 2: pause in the middle of the window
    start = 1'b0; ev = 2'b00; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t2_idle_running", 32'(run_a), 32'd0);
    check("t2_idle_done", 32'(done_a), 32'd0);
    ev = 2'b01; start = 1'b1;
    tick();
    repeat (10) tick();
    start = 1'b0;
    repeat (5) tick();
    check("t2_paused_running", 32'(run_a), 32'd1);
    start = 1'b1;
    repeat (10) tick();
    start = 1'b0; snap = 1'b1;
    tick();
    snap = 1'b0; rd_sel = 2'd2;
    tick();
    check("t2_cycle", 32'(rd_a), 32'd20);
    rd_sel = 2'd0; tick();
    check("t2_ev0", 32'(rd_a), 32'd20);
    rd_sel = 2'd1; tick();
    check("t2_ev1", 32'(rd_a), 32'd0);

    // 3: wrap vs saturate on 4-bit unbounded counters
    rst = 1'b1; ev = 2'b00;
    tick();
    rst = 1'b0;
    start = 1'b1; ev = 2'b01;
    tick();
    repeat (18) tick();
    start = 1'b0; snap = 1'b1;
    tick();
    snap = 1'b0; rd_sel = 2'd0;
    check("t3_wrap_ovf", 32'(ovf_b), 32'd5);
    check("t3_sat_ovf", 32'(ovf_c), 32'd5);
    tick();
    check("t3_wrap_ev0", 32'(rd_b), 32'd2);
    check("t3_sat_ev0", 32'(rd_c), 32'd15);
    rd_sel = 2'd2; tick();
    check("t3_wrap_cycle", 32'(rd_b), 32'd2);
    check("t3_sat_cycle", 32'(rd_c), 32'd15);

    // 4: snapshot on an incrementing edge captures the pre-increment value
    ev = 2'b00; clear = 1'b1;
    tick();
    clear = 1'b0; start = 1'b1;
    tick();
    ev = 2'b01;
    repeat (7) tick();
    snap = 1'b1; rd_sel = 2'd0;
    tick();
    snap = 1'b0; start = 1'b0; ev = 2'b00;
    check("t4_snap_valid", 32'(sv_a), 32'd1);
    tick();
    check("t4_shadow_ev0", 32'(rd_a), 32'd7);
    check("t4_snap_valid_one_cycle", 32'(sv_a), 32'd0);
    snap = 1'b1; tick(); snap = 1'b0; tick();
    check("t4_live_ev0", 32'(rd_a), 32'd8);

    // 5: clear beats snap on the same edge
    clear = 1'b1;
    tick();
    clear = 1'b0; start = 1'b1;
    tick();
    ev = 2'b01;
    repeat (5) tick();
    start = 1'b0; ev = 2'b00; clear = 1'b1; snap = 1'b1;
    tick();
    clear = 1'b0; snap = 1'b0;
    check("t5_no_snap_valid", 32'(sv_a), 32'd0);
    check("t5_idle", 32'(run_a), 32'd0);
    tick();
    check("t5_shadow_kept", 32'(rd_a), 32'd8);
    snap = 1'b1; tick(); snap = 1'b0; tick();
    check("t5_live_cleared", 32'(rd_a), 32'd0);

    // 6: async reset mid-window, then a full restart
    start = 1'b1;
    tick();
    ev = 2'b11;
    repeat (30) tick();
    start = 1'b0; snap = 1'b1; rd_sel = 2'd2;
    tick();
    tick();
    check("t6_b2b_snap_valid", 32'(sv_a), 32'd1);
    check("t6_cycle_at_30", 32'(rd_a), 32'd30);
    check("t6_running_before_rst", 32'(run_a), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_running", 32'(run_a), 32'd0);
    check("t6_rst_rd_data", 32'(rd_a), 32'd0);
    check("t6_rst_snap_valid", 32'(sv_a), 32'd0);
    check("t6_rst_overflow", 32'(ovf_b), 32'd0);
    snap = 1'b0;
    tick();
    rst = 1'b0; start = 1'b1;
    tick();
    repeat (63) tick();
    check("t6_done_not_yet", 32'(done_a), 32'd0);
    tick();
    check("t6_done", 32'(done_a), 32'd1);
    start = 1'b0; snap = 1'b1;
    tick();
    snap = 1'b0; rd_sel = 2'd2;
    tick();
    check("t6_cycle", 32'(rd_a), 32'd64);
    rd_sel = 2'd1; tick();
    check("t6_ev1", 32'(rd_a), 32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
